gcd_lcm_sched: RTL and testbench
================================

# gcd_lcm_sched

Round-robin scheduler that shares one serial-load GCD/LCM engine among NREQ requesters. It accepts an operand pair from one requester at a time and sequences the engine's two-cycle operand load. It then waits for the engine's done flag, returns the result on a single response port and pulses the engine's reset so the engine is ready for the next job. Operands of zero never reach the engine, and a watchdog aborts hung jobs.

## Interface
- SIZE, 8, operand and GCD width
- NREQ, 4, number of requesters (≥2)
- TIMEOUT, 512, maximum WAIT cycles before abort (≥2)
- clk  in  1  clock, all flops on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester job request, held until accepted
- req_a  in  NREQ*SIZE  operand A, requester i at bits [i*SIZE +: SIZE]
- req_b  in  NREQ*SIZE  operand B, same packing
- req_ready  out  NREQ  one-hot acceptance strobe, one cycle
- rsp_valid  out  1  result available, held until rsp_ready
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result
- rsp_gcd  out  SIZE  GCD result
- rsp_lcm  out  2*SIZE+1  LCM result
- rsp_err  out  1  1 = zero operand or timeout; gcd/lcm then 0
- eng_rst_n  out  1  engine reset, registered
- eng_start  out  1  engine start, registered
- eng_data  out  SIZE  engine serial operand bus, registered
- eng_done  in  1  engine done flag (level, sticky until engine reset)
- eng_gcd  in  SIZE  engine GCD result
- eng_lcm  in  2*SIZE+1  engine LCM result

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESP, CLEAR.
- IDLE:
  - Winner is the first set req_valid searching upward from last_grant+1, modulo NREQ.
  - req_ready[winner] is asserted combinationally in that cycle.
  - The operands, the winner index, and last_grant ← winner are latched.
  - If either operand is 0: rsp_err←1, gcd/lcm←0, go to RESP. Otherwise go to LOAD_A.
  - With no req_valid, stay in IDLE.
- LOAD_A: eng_start=1, eng_data=A; go to LOAD_B. The engine captures A on this edge.
- LOAD_B: eng_start=0, eng_data=B; go to WAIT and clear the timer. The engine captures B.
- WAIT:
  - If eng_done=1: latch eng_gcd and eng_lcm, set rsp_err←0, go to RESP.
  - Otherwise increment the timer. When timer reaches TIMEOUT-1 without done: rsp_err←1, gcd/lcm←0, go to RESP.
- RESP: rsp_valid=1 and all rsp_* stay stable. When rsp_ready=1, go to CLEAR.
- CLEAR: eng_rst_n=0 for exactly one cycle, then go to IDLE. CLEAR is taken after every job, including error jobs.
- eng_data outside LOAD_A and LOAD_B is 0. eng_start is 1 only in LOAD_A.
- Requests arriving outside IDLE wait; req_ready stays 0 outside IDLE.
- Simultaneous eng_done and timer expiry: done wins and the result is valid.

## Timing
- Reset values:
  - state IDLE, last_grant NREQ-1 (requester 0 has first priority).
  - req_ready 0, rsp_valid 0, rsp_id 0, rsp_gcd 0, rsp_lcm 0, rsp_err 0.
  - eng_rst_n 0, eng_start 0, eng_data 0.
- eng_rst_n rises on the first clock edge after rst_n deasserts.
- Reset mid-job aborts immediately; the engine is reset through eng_rst_n. No response is issued.
- Engine outputs are Moore, decoded from registered state. There is no combinational path from any input to any eng_* output.
- Latency, with accept at cycle T:
  - eng_start high during T+1, B presented during T+2, WAIT from T+3.
  - rsp_valid rises the cycle after eng_done is sampled high.
  - Zero-operand job: rsp_valid at T+1.
  - Timeout: rsp_valid at T+3+TIMEOUT.
- Back-to-back minimum: the next accept occurs one cycle after CLEAR, i.e. 2 cycles after the rsp handshake.
- rsp_lcm width 2*SIZE+1 matches the engine and is passed unmodified.

## Test plan
- Single job: req 2 with A=12, B=18, engine model honest → eng_start pulse at T+1, eng_data 12 then 18, rsp_id=2, gcd=6, lcm=36, err=0, one-cycle eng_rst_n low after handshake.
- Fairness: all four req_valid held with distinct operands → grant order 0,1,2,3,0; no requester granted twice while another waits.
- Zero operand: A=0, B=5 on req 1 → rsp_err=1, gcd=0, lcm=0, rsp_valid at T+1, eng_start never asserted.
- Backpressure: rsp_ready low for 10 cycles → rsp_* stable, no CLEAR, req_ready stays 0; CLEAR follows the cycle after rsp_ready=1.
- Timeout: TIMEOUT=16, engine model never asserts done → rsp_err=1 exactly 16 cycles after WAIT entry, then CLEAR.
- Reset mid-WAIT: rst_n low asynchronously → all outputs at reset values immediately, no response, next job is served from requester 0 priority.

Source files
------------

// File: rtl/gcd_lcm_sched.sv
`timescale 1ns/1ps
// Round-robin front end that time-shares one serial-load GCD/LCM engine
// between NREQ requesters, with zero-operand bypass and a WAIT watchdog.
module gcd_lcm_sched #(
  parameter int SIZE    = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SIZE-1:0]    req_a,
  input  logic [NREQ*SIZE-1:0]    req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [SIZE-1:0]         rsp_gcd,
  output logic [2*SIZE:0]         rsp_lcm,
  output logic                    rsp_err,
  output logic                    eng_rst_n,
  output logic                    eng_start,
  output logic [SIZE-1:0]         eng_data,
  input  logic                    eng_done,
  input  logic [SIZE-1:0]         eng_gcd,
  input  logic [2*SIZE:0]         eng_lcm
);
  localparam int ID_W = $clog2(NREQ);
  localparam int TW   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP, CLEAR} state_t;

  state_t          state_reg;
  logic [ID_W-1:0] last_grant_reg;
  logic [SIZE-1:0] b_reg;
  logic [TW-1:0]   timer_reg;

  logic [SIZE-1:0] a_arr [NREQ];
  logic [SIZE-1:0] b_arr [NREQ];
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*SIZE +: SIZE];
      assign b_arr[gi] = req_b[gi*SIZE +: SIZE];
    end
  endgenerate

  // Search starts just past the previous winner so every waiter is reached.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int cand;
      cand = (int'(last_grant_reg) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_reg == IDLE && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  // Engine-facing outputs are loaded with the value for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_W'(NREQ - 1);
      b_reg          <= '0;
      timer_reg      <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_gcd        <= '0;
      rsp_lcm        <= '0;
      rsp_err        <= 1'b0;
      eng_rst_n      <= 1'b0;
      eng_start      <= 1'b0;
      eng_data       <= '0;
    end else begin
      eng_rst_n <= 1'b1;
      eng_start <= 1'b0;
      eng_data  <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            last_grant_reg <= grant_idx;
            rsp_id         <= grant_idx;
            b_reg          <= b_arr[grant_idx];
            if (a_arr[grant_idx] == '0 || b_arr[grant_idx] == '0) begin
              rsp_err   <= 1'b1;
              rsp_gcd   <= '0;
              rsp_lcm   <= '0;
              rsp_valid <= 1'b1;
              state_reg <= RESP;
            end else begin
              eng_start <= 1'b1;
              eng_data  <= a_arr[grant_idx];
              state_reg <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          eng_data  <= b_reg;
          state_reg <= LOAD_B;
        end
        LOAD_B: begin
          timer_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // done is tested first so it beats a simultaneous timer expiry
          if (eng_done) begin
            rsp_gcd   <= eng_gcd;
            rsp_lcm   <= eng_lcm;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            rsp_gcd   <= '0;
            rsp_lcm   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            eng_rst_n <= 1'b0;
            state_reg <= CLEAR;
          end
        end
        CLEAR: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_lcm_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for gcd_lcm_sched: behavioural engine, round-robin model,
// randomized jobs, backpressure, zero operands, timeout and mid-job reset.
module tb_gcd_lcm_sched;
  localparam int SIZE = 8, NREQ = 4, TIMEOUT = 16, IDW = 2, LW = 2*SIZE+1;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*SIZE-1:0] req_a, req_b;
  logic                 rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]       rsp_id;
  logic [SIZE-1:0]      rsp_gcd, eng_data;
  logic [LW-1:0]        rsp_lcm;
  logic                 eng_rst_n, eng_start;
  logic                 eng_done = 1'b0;
  logic [SIZE-1:0]      eng_gcd = '0;
  logic [LW-1:0]        eng_lcm = '0;

  always #5 clk = ~clk;

  gcd_lcm_sched #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_gcd(rsp_gcd), .rsp_lcm(rsp_lcm), .rsp_err(rsp_err),
    .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_gcd(eng_gcd), .eng_lcm(eng_lcm));

  typedef struct {
    int             id;
    logic [SIZE-1:0] gcd;
    logic [LW-1:0]  lcm;
    logic           err;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, passes = 0;
  int cyc = 0;

  // model state (written only by the monitor)
  int busy = 0, lg = NREQ-1, idle_from = 0, clear_cyc = -10, cur_t = -100;
  bit cur_zero = 1'b0, rst_prev = 1'b1, prev_valid = 1'b0;
  logic [SIZE-1:0] cur_a = '0, cur_b = '0;
  logic [NREQ-1:0] accepted_mask = '0, exp_rdy;
  int next_delay = 0, w;
  exp_t e;

  // stimulus knobs (written only by the stimulus block)
  bit eng_hang = 1'b0, rand_ready = 1'b1;
  int bp_cnt = 0, fixed_delay = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SIZE-1:0] ref_gcd(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return SIZE'(x);
  endfunction

  function automatic logic [LW-1:0] ref_lcm(input int a, input int b);
    return LW'((a * b) / int'(ref_gcd(a, b)));
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
  endtask

  // Behavioural engine: A on the start edge, B on the next, done after a delay.
  int ph = 0, cnt = 0;
  logic [SIZE-1:0] ea = '0, eb = '0;
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      ph <= 0; eng_done <= 1'b0; eng_gcd <= '0; eng_lcm <= '0;
    end else begin
      case (ph)
        0: if (eng_start) begin ea <= eng_data; ph <= 1; end
        1: begin
          if (eng_hang) ph <= 3;
          else if (next_delay == 0) begin
            eng_done <= 1'b1; eng_gcd <= ref_gcd(ea, eng_data);
            eng_lcm <= ref_lcm(ea, eng_data); ph <= 3;
          end else begin
            eb <= eng_data; cnt <= next_delay - 1; ph <= 2;
          end
        end
        2: if (cnt == 0) begin
          eng_done <= 1'b1; eng_gcd <= ref_gcd(ea, eb); eng_lcm <= ref_lcm(ea, eb); ph <= 3;
        end else cnt <= cnt - 1;
        default: ;
      endcase
    end
  end

  // Monitor and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); busy = 0; lg = NREQ-1; idle_from = 0; clear_cyc = -10;
      rst_prev = 1'b1; prev_valid = 1'b0; accepted_mask = '0;
    end else begin
      check(eng_rst_n == !(cyc == clear_cyc || rst_prev), "eng_rst_n", eng_rst_n,
            !(cyc == clear_cyc || rst_prev));
      rst_prev = 1'b0;
      check(eng_start == (busy && !cur_zero && cyc == cur_t+1), "eng_start", eng_start,
            busy && !cur_zero && cyc == cur_t+1);
      if (busy && !cur_zero && cyc == cur_t+1)      check(eng_data == cur_a, "eng_data_a", eng_data, cur_a);
      else if (busy && !cur_zero && cyc == cur_t+2) check(eng_data == cur_b, "eng_data_b", eng_data, cur_b);
      else                                          check(eng_data == 0, "eng_data_idle", eng_data, 0);

      if (rsp_valid) begin
        if (sb.size() == 0) check(1'b0, "rsp_unexpected", 1, 0);
        else begin
          if (!prev_valid) check(cyc == sb[0].cyc, "rsp_latency", cyc - cur_t, sb[0].cyc - cur_t);
          check(int'(rsp_id) == sb[0].id, "rsp_id", rsp_id, sb[0].id);
          check(rsp_gcd == sb[0].gcd, "rsp_gcd", rsp_gcd, sb[0].gcd);
          check(rsp_lcm == sb[0].lcm, "rsp_lcm", rsp_lcm, sb[0].lcm);
          check(rsp_err == sb[0].err, "rsp_err", rsp_err, sb[0].err);
          if (rsp_ready) begin
            void'(sb.pop_front());
            busy = 0; idle_from = cyc + 2; clear_cyc = cyc + 1;
          end
        end
      end
      prev_valid = rsp_valid && !rsp_ready;

      exp_rdy = '0; w = 0;
      if (!busy && cyc >= idle_from)
        for (int k = 1; k <= NREQ; k++) begin
          int j;
          j = (lg + k) % NREQ;
          if (exp_rdy == 0 && req_valid[j]) begin exp_rdy[j] = 1'b1; w = j; end
        end
      check(req_ready == exp_rdy, "req_ready", req_ready, exp_rdy);
      accepted_mask = req_ready;
      if (exp_rdy != 0) begin
        busy = 1; lg = w; cur_t = cyc;
        cur_a = req_a[w*SIZE +: SIZE]; cur_b = req_b[w*SIZE +: SIZE];
        cur_zero = (cur_a == 0) || (cur_b == 0);
        next_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, TIMEOUT-1));
        e.id = w;
        if (cur_zero) begin
          e.gcd = '0; e.lcm = '0; e.err = 1'b1; e.cyc = cyc + 1;
        end else if (eng_hang) begin
          e.gcd = '0; e.lcm = '0; e.err = 1'b1; e.cyc = cyc + 3 + TIMEOUT;
        end else begin
          e.gcd = ref_gcd(cur_a, cur_b); e.lcm = ref_lcm(cur_a, cur_b);
          e.err = 1'b0; e.cyc = cyc + 4 + next_delay;
        end
        sb.push_back(e);
      end
    end
  end

  // The only way the stimulus advances time: retire accepted requests, drive rsp_ready.
  task automatic tick();
    @(posedge clk); #1;
    req_valid = req_valid & ~accepted_mask;
    if (bp_cnt > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) bp_cnt--;
    end else rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
  endtask

  task automatic issue(input int i, input int a, input int b);
    int n;
    n = 0;
    while (req_valid[i] && n < 400) begin tick(); n++; end
    if (req_valid[i]) check(1'b0, "issue_timeout", n, 0);
    else begin
      req_a[i*SIZE +: SIZE] = SIZE'(a);
      req_b[i*SIZE +: SIZE] = SIZE'(b);
      req_valid[i] = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(req_valid == 0 && sb.size() == 0 && busy == 0) && n < budget) begin tick(); n++; end
    check(req_valid == 0 && sb.size() == 0 && busy == 0, "drain", n, budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(req_ready == 0 && rsp_valid == 0 && rsp_id == 0 && rsp_gcd == 0 &&
          rsp_lcm == 0 && rsp_err == 0 && eng_rst_n == 0 && eng_start == 0 &&
          eng_data == 0, tag,
          {rsp_valid, rsp_err, eng_rst_n, eng_start, req_ready, eng_data}, 0);
  endtask

  initial begin
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    check_reset_outputs("reset_values");
    tick();
    rst_n = 1'b1;

    // single honest job, then a done that lands on the last watchdog cycle
    fixed_delay = 2;
    issue(2, 12, 18); wait_idle(100);
    fixed_delay = TIMEOUT - 1;
    issue(0, 200, 150); wait_idle(100);
    fixed_delay = -1;

    // fairness: all requesters pending, each re-requests as soon as served
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) issue(i, 10 + 7*i + r, 4 + 3*i + r);
    wait_idle(600);

    // zero operands bypass the engine
    issue(1, 0, 5); wait_idle(50);
    issue(3, 7, 0); wait_idle(50);

    // backpressure held for 10 valid cycles
    bp_cnt = 10;
    issue(0, 9, 6); wait_idle(100);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int i, a, b;
      i = $urandom_range(0, NREQ-1);
      a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      issue(i, a, b);
      if ($urandom_range(0, 3) == 0) tick();
    end
    wait_idle(3000);

    // watchdog timeout
    eng_hang = 1'b1;
    issue(3, 30, 45); wait_idle(100);

    // asynchronous reset while the job sits in WAIT
    issue(2, 8, 12);
    repeat (8) tick();
    #1 rst_n = 1'b0; req_valid = '0;
    #1 check_reset_outputs("async_reset");
    tick(); tick();
    rst_n = 1'b1;
    eng_hang = 1'b0;
    for (int i = 0; i < NREQ; i++) issue(i, 21 + i, 14 + 2*i);
    wait_idle(600);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
